// File: rtl/video_line_fetch_arbiter.sv
// Line prefetch / CPU arbiter for a shared single-port video RAM channel.
// Fetches the next scanline into a double-buffered line store during hblank and serves pixels from it.
module video_line_fetch_arbiter #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int V_TOTAL        = 525,
  parameter int WORDS_PER_LINE = 40,
  parameter int ADDR_WIDTH     = 16,
  parameter int FB_BASE        = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  display_active,
  output logic                  pixel,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_ack,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  input  logic                  ram_ack,
  output logic                  fetch_busy,
  output logic                  underrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_VID  = 2'd1;
  localparam logic [1:0] ST_CPU  = 2'd2;

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [9:0] H_TRIG     = 10'(H_ACTIVE);
  localparam logic [9:0] V_FETCH_LT = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] V_WRAP     = 10'(V_TOTAL - 1);

  logic [1:0]       state;
  logic             fetch_pending;
  logic             discard;
  logic [9:0]       target_line;
  logic [IDX_W-1:0] word_idx;
  logic [15:0]      line_buf [2][WORDS_PER_LINE];

  logic             trigger;
  logic [9:0]       next_line;
  logic             buf_we;
  logic [15:0]      rd_word;

  function automatic logic [ADDR_WIDTH-1:0] vid_addr(input logic [9:0] line,
                                                     input logic [IDX_W-1:0] idx);
    logic [31:0] a;
    a = 32'(FB_BASE) + 32'(line) * 32'(WORDS_PER_LINE) + 32'(idx);
    return a[ADDR_WIDTH-1:0];
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    trigger   = (hpos == H_TRIG) && ((vpos < V_FETCH_LT) || (vpos == V_WRAP));
    next_line = (vpos == V_WRAP) ? 10'd0 : vpos + 10'd1;
    buf_we    = (state == ST_VID) && ram_ack && !discard && !trigger;
    rd_word   = line_buf[vpos[0]][hpos[9:4]];
  end

  assign fetch_busy = fetch_pending;

  // NOTE: the line store has no reset; its contents are don't-care until the first fetch lands.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[target_line[0]][word_idx] <= ram_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pixel <= 1'b0;
    else          pixel <= display_active ? rd_word[~hpos[3:0]] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      fetch_pending <= 1'b0;
      discard       <= 1'b0;
      target_line   <= '0;
      word_idx      <= '0;
      ram_req       <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      cpu_rdata     <= '0;
      cpu_ack       <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A trigger this cycle counts as pending so video beats a simultaneous CPU request.
          if (fetch_pending || trigger) begin
            state    <= ST_VID;
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= trigger ? vid_addr(next_line, '0) : vid_addr(target_line, word_idx);
          end else if (cpu_req) begin
            state     <= ST_CPU;
            ram_req   <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
          end
        end
        ST_VID: begin
          if (ram_ack) begin
            discard <= 1'b0;
            if (trigger) begin
              ram_addr <= vid_addr(next_line, '0);
            end else if (discard) begin
              ram_addr <= vid_addr(target_line, word_idx);
            end else if (word_idx == LAST_IDX) begin
              state         <= ST_IDLE;
              ram_req       <= 1'b0;
              fetch_pending <= 1'b0;
            end else begin
              word_idx <= word_idx + 1'b1;
              ram_addr <= vid_addr(target_line, word_idx + 1'b1);
            end
          end else if (trigger) begin
            // The word in flight belongs to the abandoned line; drop it when it returns.
            discard <= 1'b1;
          end
        end
        ST_CPU: begin
          if (ram_ack) begin
            cpu_ack <= 1'b1;
            if (!ram_we) cpu_rdata <= ram_rdata;
            state   <= ST_IDLE;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ram_req <= 1'b0;
        end
      endcase

      // Placed last so a new trigger overrides completion of the previous fetch.
      if (trigger) begin
        target_line   <= next_line;
        word_idx      <= '0;
        fetch_pending <= 1'b1;
        if (fetch_pending) underrun <= 1'b1;
      end
      if (hpos == 10'd0 && vpos == target_line && vpos < V_VIS && fetch_pending)
        underrun <= 1'b1;
    end
  end

endmodule
